// File: rtl/axi_wr_burst_buf.sv
// axi_wr_burst_buf
// Collects an upstream stream into whole BURST_LEN-beat groups and
// releases each group to an AXI write master as one unbroken burst.
// Optional feature macro: WR_PAD_LAST_EN. When it is defined, a packet
// ending part-way through a group is zero-padded up to the group boundary.

module axi_wr_burst_buf #(
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LEN    = 16,
    parameter int DEPTH_BURSTS = 4
) (
    input  logic                                          S_WR_aclk,
    input  logic                                          S_WR_areset,
    input  logic [DATA_WIDTH-1:0]                         S_IN_tdata,
    input  logic                                          S_IN_tvalid,
    input  logic                                          S_IN_tlast,
    output logic                                          S_IN_tready,
    output logic [DATA_WIDTH-1:0]                         M_WR_tdata,
    output logic                                          M_WR_tvalid,
    output logic                                          M_WR_tlast,
    input  logic                                          M_WR_tready,
    output logic [$clog2(BURST_LEN*DEPTH_BURSTS):0]       fill_level
);

    localparam int DEPTH  = BURST_LEN * DEPTH_BURSTS;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);

`ifdef WR_PAD_LAST_EN
    typedef enum logic {IN_DATA, IN_PAD} inState_t;
`else
    typedef enum logic {IN_DATA} inState_t;
`endif
    typedef enum logic {OUT_IDLE, OUT_BURST} outState_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wrPtr_q,  wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q,  rdPtr_d;
    logic [FILL_W-1:0] fill_q,   fill_d;
    logic [FILL_W-1:0] avail_q,  avail_d;
    logic [CNT_W-1:0]  inCnt_q,  inCnt_d;
    logic [CNT_W-1:0]  outCnt_q, outCnt_d;
    inState_t          inState_q,  inState_d;
    outState_t         outState_q, outState_d;

    logic                  full;
    logic                  inPadding;
    logic                  wrEn;
    logic                  rdEn;
    logic                  groupDone;
    logic                  burstStart;
    logic [DATA_WIDTH-1:0] wrData;

    // Write side: accept stream beats (or pad words) whenever there is room
    always_comb begin
        full      = (fill_q == FULL_LEVEL);
`ifdef WR_PAD_LAST_EN
        inPadding = (inState_q == IN_PAD);
`else
        inPadding = 1'b0;
`endif
        S_IN_tready = !S_WR_areset && !full && (inState_q == IN_DATA);
        wrEn        = !full && (inPadding || ((inState_q == IN_DATA) && S_IN_tvalid));
        wrData      = inPadding ? '0 : S_IN_tdata;
        groupDone   = wrEn && (inCnt_q == LAST_BEAT);
    end

`ifndef WR_PAD_LAST_EN
    // Packet boundaries carry no meaning when padding is compiled out
    logic unusedTlast;
    assign unusedTlast = S_IN_tlast;
`endif

    // Input FSM: leaves IN_DATA only to pad out a short final group
    always_comb begin
        inState_d = inState_q;
`ifdef WR_PAD_LAST_EN
        case (inState_q)
            IN_DATA: if (wrEn && S_IN_tlast && (inCnt_q != LAST_BEAT)) inState_d = IN_PAD;
            IN_PAD:  if (groupDone) inState_d = IN_DATA;
            default: inState_d = IN_DATA;
        endcase
`else
        inState_d = IN_DATA;
`endif
    end

    // Read side: a burst is presented only once a full group is stored
    always_comb begin
        M_WR_tvalid = !S_WR_areset && (outState_q == OUT_BURST);
        M_WR_tlast  = M_WR_tvalid && (outCnt_q == LAST_BEAT);
        M_WR_tdata  = mem_q[rdPtr_q];
        rdEn        = M_WR_tvalid && M_WR_tready;
        burstStart  = (outState_q == OUT_IDLE) && (avail_q != '0);
    end

    // Output FSM: hold tvalid for the whole burst, drop it after tlast
    always_comb begin
        outState_d = outState_q;
        case (outState_q)
            OUT_IDLE:  if (avail_q != '0) outState_d = OUT_BURST;
            OUT_BURST: if (rdEn && M_WR_tlast) outState_d = OUT_IDLE;
            default:   outState_d = OUT_IDLE;
        endcase
    end

    // Pointer, beat-counter, occupancy and burst-available bookkeeping
    always_comb begin
        wrPtr_d  = wrEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d  = rdEn ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        inCnt_d  = inCnt_q;
        outCnt_d = outCnt_q;
        if (wrEn) begin
            inCnt_d = groupDone ? '0 : inCnt_q + CNT_W'(1);
        end
        if (rdEn) begin
            outCnt_d = M_WR_tlast ? '0 : outCnt_q + CNT_W'(1);
        end
        fill_d = fill_q;
        case ({wrEn, rdEn})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
        avail_d = avail_q;
        case ({groupDone, burstStart})
            2'b10:   avail_d = avail_q + FILL_W'(1);
            2'b01:   avail_d = avail_q - FILL_W'(1);
            default: avail_d = avail_q;
        endcase
    end

    // State registers; reset throws away everything buffered
    always_ff @(posedge S_WR_aclk) begin
        if (S_WR_areset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            fill_q     <= '0;
            avail_q    <= '0;
            inCnt_q    <= '0;
            outCnt_q   <= '0;
            inState_q  <= IN_DATA;
            outState_q <= OUT_IDLE;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            fill_q     <= fill_d;
            avail_q    <= avail_d;
            inCnt_q    <= inCnt_d;
            outCnt_q   <= outCnt_d;
            inState_q  <= inState_d;
            outState_q <= outState_d;
        end
    end

    // Storage array; contents need no reset because pointers gate access
    always_ff @(posedge S_WR_aclk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wrData;
        end
    end

    assign fill_level = fill_q;

endmodule

// File: tb/tb_axi_wr_burst_buf.sv
// Directed testbench for axi_wr_burst_buf with default parameters.
// Expectations adapt to whether WR_PAD_LAST_EN is defined.

module tb_axi_wr_burst_buf;

    logic        clk;
    logic        reset;
    logic [63:0] sInData;
    logic        sInValid;
    logic        sInLast;
    logic        sInReady;
    logic [63:0] mWrData;
    logic        mWrValid;
    logic        mWrLast;
    logic        mWrReady;
    logic [6:0]  fillLevel;

    int          errCount   = 0;
    int          checkCount = 0;

    logic [63:0] outData [$];
    logic        outLast [$];

    axi_wr_burst_buf dut (
        .S_WR_aclk   (clk),
        .S_WR_areset (reset),
        .S_IN_tdata  (sInData),
        .S_IN_tvalid (sInValid),
        .S_IN_tlast  (sInLast),
        .S_IN_tready (sInReady),
        .M_WR_tdata  (mWrData),
        .M_WR_tvalid (mWrValid),
        .M_WR_tlast  (mWrLast),
        .M_WR_tready (mWrReady),
        .fill_level  (fillLevel)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every accepted output beat, sampled mid-cycle
    always @(negedge clk) begin
        if (mWrValid && mWrReady) begin
            outData.push_back(mWrData);
            outLast.push_back(mWrLast);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Push count beats base..base+count-1, optionally with tlast on the final one
    task automatic applyStimulus(input logic [63:0] base, input int count, input logic lastOnFinal);
        logic accepted;
        for (int i = 0; i < count; i++) begin
            sInData  = base + 64'(i);
            sInValid = 1'b1;
            sInLast  = lastOnFinal && (i == count - 1);
            accepted = 1'b0;
            for (int g = 0; g < 300 && !accepted; g++) begin
                accepted = sInReady;
                tick();
            end
            if (!accepted) checkOutput("input stall timeout", 64'd0, 64'd1);
        end
        sInValid = 1'b0;
        sInLast  = 1'b0;
    endtask

    task automatic waitBeats(input int n, input int limit);
        for (int g = 0; g < limit && outData.size() < n; g++) tick();
        checkOutput("output beat count", 64'(outData.size()), 64'(n));
    endtask

    task automatic clearQueues();
        outData.delete();
        outLast.delete();
    endtask

    initial begin
        int          acc;
        logic        accNow;
        logic [63:0] expData;

        reset    = 1'b1;
        sInData  = '0;
        sInValid = 1'b0;
        sInLast  = 1'b0;
        mWrReady = 1'b1;

        // Reset state
        tick();
        tick();
        checkOutput("reset tready", 64'(sInReady), 64'd0);
        checkOutput("reset tvalid", 64'(mWrValid), 64'd0);
        checkOutput("reset tlast", 64'(mWrLast), 64'd0);
        checkOutput("reset fill", 64'(fillLevel), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset tready", 64'(sInReady), 64'd1);

        // 15 beats hold back; the 16th releases the burst two cycles later
        $display("[TB] partial group then release");
        applyStimulus(64'h1, 15, 1'b0);
        repeat (4) tick();
        checkOutput("15 beats tvalid", 64'(mWrValid), 64'd0);
        checkOutput("15 beats fill", 64'(fillLevel), 64'd15);
        clearQueues();
        sInData  = 64'h10;
        sInValid = 1'b1;
        tick();
        sInValid = 1'b0;
        checkOutput("beat16 fill", 64'(fillLevel), 64'd16);
        checkOutput("latency cycle1 tvalid", 64'(mWrValid), 64'd0);
        tick();
        checkOutput("latency cycle2 tvalid", 64'(mWrValid), 64'd1);
        checkOutput("fwft head data", mWrData, 64'h1);
        waitBeats(16, 40);
        for (int i = 0; i < outData.size() && i < 16; i++) begin
            checkOutput($sformatf("b1 data %0d", i), outData[i], 64'(i + 1));
            checkOutput($sformatf("b1 last %0d", i), 64'(outLast[i]), 64'(i == 15));
        end
        tick();
        checkOutput("b1 drained fill", 64'(fillLevel), 64'd0);
        checkOutput("b1 drained tvalid", 64'(mWrValid), 64'd0);

        // Fill to capacity with the master stalled, then drain across pointer wrap
        $display("[TB] full buffer and wrap");
        clearQueues();
        mWrReady = 1'b0;
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            sInData  = 64'h100 + 64'(acc);
            sInValid = 1'b1;
            accNow   = sInReady;
            tick();
            if (accNow) acc++;
        end
        sInValid = 1'b0;
        checkOutput("full accepted", 64'(acc), 64'd64);
        checkOutput("full tready", 64'(sInReady), 64'd0);
        checkOutput("full fill", 64'(fillLevel), 64'd64);
        mWrReady = 1'b1;
        waitBeats(64, 200);
        for (int i = 0; i < outData.size() && i < 64; i++) begin
            checkOutput($sformatf("wrap data %0d", i), outData[i], 64'h100 + 64'(i));
            checkOutput($sformatf("wrap last %0d", i), 64'(outLast[i]), 64'((i % 16) == 15));
        end
        tick();
        checkOutput("wrap drained fill", 64'(fillLevel), 64'd0);

        // Short packet: padded out with zeros, or left waiting for more input
        $display("[TB] short packet with tlast");
        clearQueues();
        applyStimulus(64'h200, 5, 1'b1);
`ifdef WR_PAD_LAST_EN
        checkOutput("pad tready low", 64'(sInReady), 64'd0);
        waitBeats(16, 80);
        for (int i = 0; i < outData.size() && i < 16; i++) begin
            expData = (i < 5) ? 64'h200 + 64'(i) : 64'd0;
            checkOutput($sformatf("pad data %0d", i), outData[i], expData);
            checkOutput($sformatf("pad last %0d", i), 64'(outLast[i]), 64'(i == 15));
        end
        tick();
        checkOutput("pad drained fill", 64'(fillLevel), 64'd0);
`else
        repeat (30) tick();
        checkOutput("nopad beat count", 64'(outData.size()), 64'd0);
        checkOutput("nopad fill", 64'(fillLevel), 64'd5);
        checkOutput("nopad tvalid", 64'(mWrValid), 64'd0);
        applyStimulus(64'h205, 11, 1'b0);
        waitBeats(16, 60);
        for (int i = 0; i < outData.size() && i < 16; i++) begin
            checkOutput($sformatf("nopad data %0d", i), outData[i], 64'h200 + 64'(i));
            checkOutput($sformatf("nopad last %0d", i), 64'(outLast[i]), 64'(i == 15));
        end
        tick();
        checkOutput("nopad drained fill", 64'(fillLevel), 64'd0);
`endif

        // Reset in the middle of an output burst
        $display("[TB] reset mid-burst");
        clearQueues();
        applyStimulus(64'h300, 16, 1'b0);
        for (int g = 0; g < 10 && !mWrValid; g++) tick();
        checkOutput("mid tvalid up", 64'(mWrValid), 64'd1);
        repeat (7) tick();
        checkOutput("mid beats before reset", 64'(outData.size()), 64'd7);
        checkOutput("mid beat8 data", mWrData, 64'h307);
        reset = 1'b1;
        tick();
        checkOutput("mid reset tvalid", 64'(mWrValid), 64'd0);
        checkOutput("mid reset tlast", 64'(mWrLast), 64'd0);
        checkOutput("mid reset tready", 64'(sInReady), 64'd0);
        checkOutput("mid reset fill", 64'(fillLevel), 64'd0);
        reset = 1'b0;
        repeat (30) tick();
        checkOutput("no partial burst", 64'(outData.size()), 64'd7);
        checkOutput("idle after reset", 64'(mWrValid), 64'd0);
        clearQueues();
        applyStimulus(64'h400, 16, 1'b0);
        waitBeats(16, 40);
        for (int i = 0; i < outData.size() && i < 16; i++) begin
            checkOutput($sformatf("clean data %0d", i), outData[i], 64'h400 + 64'(i));
            checkOutput($sformatf("clean last %0d", i), 64'(outLast[i]), 64'(i == 15));
        end

        // Toggling master ready with input streaming concurrently
        $display("[TB] toggling ready");
        tick();
        clearQueues();
        acc = 0;
        for (int g = 0; g < 400 && !(acc == 48 && outData.size() >= 48); g++) begin
            if (acc < 48) begin
                sInData  = 64'h500 + 64'(acc);
                sInValid = 1'b1;
                accNow   = sInReady;
            end else begin
                sInValid = 1'b0;
                accNow   = 1'b0;
            end
            mWrReady = ~mWrReady;
            tick();
            if (accNow) acc++;
        end
        sInValid = 1'b0;
        mWrReady = 1'b1;
        checkOutput("toggle accepted", 64'(acc), 64'd48);
        checkOutput("toggle beat count", 64'(outData.size()), 64'd48);
        for (int i = 0; i < outData.size() && i < 48; i++) begin
            checkOutput($sformatf("toggle data %0d", i), outData[i], 64'h500 + 64'(i));
            checkOutput($sformatf("toggle last %0d", i), 64'(outLast[i]), 64'((i % 16) == 15));
        end
        repeat (20) tick();
        checkOutput("toggle extra beats", 64'(outData.size()), 64'd48);
        checkOutput("toggle final tvalid", 64'(mWrValid), 64'd0);
        checkOutput("toggle final fill", 64'(fillLevel), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_buf.md
AXI_WR_BURST_BUF -- requirements
Module: axi_wr_burst_buf

Interface
REQ-001: The block SHALL expose parameter DATA_WIDTH, default 64, giving the stream data width (32, 64 or 128).
REQ-002: The block SHALL expose parameter BURST_LEN, default 16, giving the beats per output burst (1-256).
REQ-003: The block SHALL expose parameter DEPTH_BURSTS, default 4, giving the buffer capacity in whole bursts; total depth is BURST_LEN*DEPTH_BURSTS words, a power of 2.
REQ-004: S_WR_aclk  in  1  single clock; one clock, all logic on rising edge.
REQ-005: S_WR_areset  in  1  reset; synchronous, active-high.
REQ-006: S_IN_tdata  in  DATA_WIDTH  upstream stream data.
REQ-007: S_IN_tvalid  in  1  upstream beat valid.
REQ-008: S_IN_tlast  in  1  upstream packet end.
REQ-009: S_IN_tready  out  1  buffer accepts beat.
REQ-010: M_WR_tdata  out  DATA_WIDTH  data to AXI write master.
REQ-011: M_WR_tvalid  out  1  burst beat valid.
REQ-012: M_WR_tlast  out  1  final beat of a BURST_LEN burst.
REQ-013: M_WR_tready  in  1  AXI write master accepts beat.
REQ-014: fill_level  out  clog2(depth)+1  words currently stored.

Function
REQ-015: Beat transfer SHALL occur on a port only when valid and ready are both high on a rising edge.
REQ-016: S_IN_tready SHALL be high when the buffer is not full and the input FSM is in IN_DATA.
REQ-017: Stored words SHALL leave in write order; pointers SHALL wrap modulo depth.
REQ-018: A burst-available counter SHALL increment when the word completing a BURST_LEN group is written, and decrement when the output FSM enters OUT_BURST; simultaneous increment and decrement SHALL leave it unchanged.
REQ-019: The output FSM SHALL have states OUT_IDLE and OUT_BURST; OUT_IDLE->OUT_BURST when burst-available > 0; OUT_BURST->OUT_IDLE on the accepted beat with M_WR_tlast high.
REQ-020: M_WR_tvalid SHALL be high throughout OUT_BURST and low in OUT_IDLE, so a burst is never presented partially or with bubbles.
REQ-021: M_WR_tdata SHALL present the head word combinationally (first-word fall-through); latency from completing-word write to M_WR_tvalid SHALL be 2 cycles.
REQ-022: M_WR_tlast SHALL be high when the output beat counter equals BURST_LEN-1; the counter SHALL clear on that beat's acceptance.
REQ-023: fill_level SHALL update in the cycle after each transfer; a simultaneous write and read SHALL leave it unchanged.
REQ-024: With the buffer full, S_IN_tready SHALL be low and no word SHALL be overwritten.
REQ-025: The input beat counter (0..BURST_LEN-1) SHALL advance on every stored word and wrap to 0 after BURST_LEN-1.

Reset
REQ-026: While S_WR_areset is high at a clock edge, pointers, counters, fill_level and burst-available SHALL clear, both FSMs SHALL go idle (IN_DATA, OUT_IDLE), and S_IN_tready, M_WR_tvalid, M_WR_tlast SHALL be 0.
REQ-027: Reset asserted mid-burst SHALL discard all buffered data; no partial burst SHALL be emitted afterwards.
REQ-028: M_WR_tdata SHALL be don't-care while M_WR_tvalid is 0.

Configuration
REQ-029: Macro WR_PAD_LAST_EN SHALL compile in tail padding.
REQ-030: With WR_PAD_LAST_EN defined, accepting S_IN_tlast with input beat counter != BURST_LEN-1 SHALL move the input FSM to IN_PAD, writing zero words (one per non-full cycle, S_IN_tready low) until the group completes, then back to IN_DATA.
REQ-031: Without WR_PAD_LAST_EN, S_IN_tlast SHALL be ignored, IN_PAD SHALL not exist, and a partial group SHALL stay buffered until filled by later input.

Verification
REQ-032: Reset, then 16 beats 0x1..0x10 continuous, M_WR_tready=1 -> 16-beat burst 0x1..0x10, tlast only on 0x10, tvalid 2 cycles after beat 16 written.
REQ-033: 15 beats only -> M_WR_tvalid stays 0, fill_level=15; 16th beat -> burst released.
REQ-034: M_WR_tready=0, 80 beats offered -> 64 accepted, S_IN_tready low, fill_level=64; release ready -> 4 bursts, data intact, pointer wrap verified.
REQ-035: WR_PAD_LAST_EN defined, 5 beats with tlast on 5th -> 11 zero words appended, burst of 16 emitted; undefined -> no output, fill_level=5.
REQ-036: S_WR_areset pulsed during beat 8 of an output burst -> outputs 0 next cycle, fill_level=0, next 16 input beats form a clean burst.
REQ-037: M_WR_tready toggled every cycle during concurrent input -> no data loss or duplication; burst-available consistent on simultaneous inc/dec.
